// File: rtl/ldpe_wr_sched_if.sv
// Bus bundle between the requesters, the write scheduler and the LDPE latch bank.
// The master side is the requester/bank environment; the slave side is the scheduler.
interface ldpe_wr_sched_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    REQ;
  logic [NREQ*AW-1:0] ADDR;
  logic [NREQ*DW-1:0] DATA;
  logic               PRE_REQ;
  logic [NREQ-1:0]    GNT;
  logic               PRE_ACK;
  logic               BUSY;
  logic [DW-1:0]      LAT_D;
  logic [(1<<AW)-1:0] LAT_G;
  logic               LAT_GE;
  logic               LAT_PRE;

  modport master (
    output REQ, ADDR, DATA, PRE_REQ,
    input  GNT, PRE_ACK, BUSY, LAT_D, LAT_G, LAT_GE, LAT_PRE
  );

  modport slave (
    input  REQ, ADDR, DATA, PRE_REQ,
    output GNT, PRE_ACK, BUSY, LAT_D, LAT_G, LAT_GE, LAT_PRE
  );
endinterface

// File: rtl/ldpe_wr_sched.sv
// Round-robin write scheduler for a bank of LDPE transparent latches: sequences
// gate-select / enable / hold so D and G are frozen around every GE pulse, plus bank preset.
module ldpe_wr_sched #(
  parameter int NREQ      = 4,
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  ldpe_wr_sched_if.slave  bus
);

  localparam int NW = 1 << AW;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    OPEN   = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4,
    PRESET = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [DW-1:0]   lat_d_q, lat_d_d;
  logic [NW-1:0]   lat_g_q, lat_g_d;
  logic            lat_ge_q, lat_ge_d;
  logic            lat_pre_q, lat_pre_d;
  logic            busy_q, busy_d;
  logic            pre_ack_q, pre_ack_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic            found_s;
  logic [PW-1:0]   sel_s;
  int              idx_s;

  function automatic logic [NW-1:0] word_onehot(input logic [AW-1:0] a);
    logic [NW-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  function automatic logic [NREQ-1:0] req_onehot(input logic [PW-1:0] w);
    logic [NREQ-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
    if (int'(w) == NREQ - 1) begin
      return '0;
    end else begin
      return w + PW'(1);
    end
  endfunction

  // Pick the first requesting index at or after the round-robin pointer, wrapping.
  always_comb begin
    found_s = 1'b0;
    sel_s   = ptr_q;
    idx_s   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s = (int'(ptr_q) + i) % NREQ;
      if (!found_s && bus.REQ[idx_s]) begin
        found_s = 1'b1;
        sel_s   = PW'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Sequencer next-state; every output is computed here for the following cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    lat_d_d   = lat_d_q;
    lat_g_d   = lat_g_q;
    lat_ge_d  = 1'b0;
    lat_pre_d = 1'b0;
    gnt_d     = '0;
    pre_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.PRE_REQ) begin
          state_d   = PRESET;
          lat_pre_d = 1'b1;
          lat_g_d   = '0;
        end else if (found_s) begin
          state_d = SETUP;
          win_d   = sel_s;
          ptr_d   = ptr_after(sel_s);
          cnt_d   = 8'(SETUP_CYC - 1);
          lat_d_d = bus.DATA[int'(sel_s)*DW +: DW];
          lat_g_d = word_onehot(bus.ADDR[int'(sel_s)*AW +: AW]);
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d  = OPEN;
          lat_ge_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OPEN: begin
        state_d = HOLD;
        cnt_d   = 8'(HOLD_CYC - 1);
      end
      HOLD: begin
        // Gate select drops only after the full hold window has elapsed.
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          lat_g_d = '0;
          gnt_d   = req_onehot(win_q);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      PRESET: begin
        state_d   = DONE;
        pre_ack_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, cleared by the synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= 8'd0;
      lat_d_q   <= '0;
      lat_g_q   <= '0;
      lat_ge_q  <= 1'b0;
      lat_pre_q <= 1'b0;
      busy_q    <= 1'b0;
      pre_ack_q <= 1'b0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      lat_d_q   <= lat_d_d;
      lat_g_q   <= lat_g_d;
      lat_ge_q  <= lat_ge_d;
      lat_pre_q <= lat_pre_d;
      busy_q    <= busy_d;
      pre_ack_q <= pre_ack_d;
      gnt_q     <= gnt_d;
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.PRE_ACK = pre_ack_q;
  assign bus.BUSY    = busy_q;
  assign bus.LAT_D   = lat_d_q;
  assign bus.LAT_G   = lat_g_q;
  assign bus.LAT_GE  = lat_ge_q;
  assign bus.LAT_PRE = lat_pre_q;

endmodule

// File: tb/tb_ldpe_wr_sched.sv
// Directed bench for ldpe_wr_sched: a default-timing instance and a stretched
// (SETUP_CYC=3, HOLD_CYC=2) instance, checked cycle by cycle against hand-computed values.
module tb_ldpe_wr_sched;

  logic clk = 1'b0;
  logic rst_n0;
  logic rst_n1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ldpe_wr_sched_if #(.NREQ(4), .AW(3), .DW(8)) bus0 ();
  ldpe_wr_sched_if #(.NREQ(4), .AW(3), .DW(8)) bus1 ();

  ldpe_wr_sched #(.NREQ(4), .AW(3), .DW(8), .SETUP_CYC(1), .HOLD_CYC(1)) dut0 (
    .CLK(clk), .RST_N(rst_n0), .bus(bus0)
  );
  ldpe_wr_sched #(.NREQ(4), .AW(3), .DW(8), .SETUP_CYC(3), .HOLD_CYC(2)) dut1 (
    .CLK(clk), .RST_N(rst_n1), .bus(bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    bus0.REQ = '0; bus0.ADDR = '0; bus0.DATA = '0; bus0.PRE_REQ = 1'b0;
    bus1.REQ = '0; bus1.ADDR = '0; bus1.DATA = '0; bus1.PRE_REQ = 1'b0;
    tick(); tick();
    n_checks++; if (bus0.GNT !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus0.GNT); end
    n_checks++; if (bus0.PRE_ACK !== 1'b0) begin n_fail++; $display("FAIL reset_pre_ack: got %b want 0", bus0.PRE_ACK); end
    n_checks++; if (bus0.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus0.BUSY); end
    n_checks++; if (bus0.LAT_D !== 8'h00) begin n_fail++; $display("FAIL reset_lat_d: got %h want 00", bus0.LAT_D); end
    n_checks++; if (bus0.LAT_G !== 8'h00) begin n_fail++; $display("FAIL reset_lat_g: got %h want 00", bus0.LAT_G); end
    n_checks++; if (bus0.LAT_GE !== 1'b0) begin n_fail++; $display("FAIL reset_lat_ge: got %b want 0", bus0.LAT_GE); end
    n_checks++; if (bus0.LAT_PRE !== 1'b0) begin n_fail++; $display("FAIL reset_lat_pre: got %b want 0", bus0.LAT_PRE); end
    n_checks++; if (bus1.BUSY !== 1'b0 || bus1.LAT_G !== 8'h00) begin n_fail++; $display("FAIL reset_dut1: got busy=%b g=%h want 0/00", bus1.BUSY, bus1.LAT_G); end
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    logic [7:0] exp_g;
    logic [3:0] exp_gnt;
    bus0.REQ = 4'b0100; bus0.ADDR[2*3 +: 3] = 3'd5; bus0.DATA[2*8 +: 8] = 8'hA7;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_g   = (c <= 3) ? 8'h20 : 8'h00;
      exp_gnt = (c == 4) ? 4'b0100 : 4'b0000;
      n_checks++; if (bus0.LAT_G !== exp_g) begin n_fail++; $display("FAIL single_lat_g c%0d: got %h want %h", c, bus0.LAT_G, exp_g); end
      n_checks++; if (bus0.LAT_D !== 8'hA7) begin n_fail++; $display("FAIL single_lat_d c%0d: got %h want a7", c, bus0.LAT_D); end
      n_checks++; if (bus0.LAT_GE !== (c == 2)) begin n_fail++; $display("FAIL single_lat_ge c%0d: got %b want %b", c, bus0.LAT_GE, (c == 2)); end
      n_checks++; if (bus0.GNT !== exp_gnt) begin n_fail++; $display("FAIL single_gnt c%0d: got %b want %b", c, bus0.GNT, exp_gnt); end
      n_checks++; if (bus0.BUSY !== (c <= 4)) begin n_fail++; $display("FAIL single_busy c%0d: got %b want %b", c, bus0.BUSY, (c <= 4)); end
      if (c == 4) bus0.REQ = 4'b0000;
    end
  endtask

  // Serves up to n grants from req_v, expecting order o0,o1,o2 then 3, five cycles apart.
  task automatic serve_sequence(input logic [3:0] req_v, input int o0, input int o1,
                                input int o2, input int o3, input int n, input string tag);
    int ord[4];
    int got;
    int last;
    logic [3:0] exp_gnt;
    ord[0] = o0; ord[1] = o1; ord[2] = o2; ord[3] = o3;
    got = 0; last = -1;
    bus0.REQ = req_v;
    for (int c = 1; c <= 40 && got < n; c++) begin
      tick();
      if (bus0.GNT !== 4'b0000) begin
        exp_gnt = 4'b0001 << ord[got];
        n_checks++; if (bus0.GNT !== exp_gnt) begin n_fail++; $display("FAIL %s_order%0d: got %b want %b", tag, got, bus0.GNT, exp_gnt); end
        n_checks++; if (c - last !== ((last < 0) ? c + 1 - 4 + 4 : 5) && last >= 0) begin n_fail++; $display("FAIL %s_spacing%0d: got %0d want 5", tag, got, c - last); end
        if (last < 0) begin
          n_checks++; if (c !== 4) begin n_fail++; $display("FAIL %s_first_latency: got %0d want 4", tag, c); end
        end
        n_checks++; if (bus0.LAT_D !== 8'(8'h10 + ord[got])) begin n_fail++; $display("FAIL %s_data%0d: got %h want %h", tag, got, bus0.LAT_D, 8'(8'h10 + ord[got])); end
        bus0.REQ = bus0.REQ & ~bus0.GNT;
        last = c;
        got++;
      end
    end
    n_checks++; if (got !== n) begin n_fail++; $display("FAIL %s_timeout: got %0d grants want %0d", tag, got, n); end
    bus0.REQ = 4'b0000;
    tick();
    n_checks++; if (bus0.BUSY !== 1'b0) begin n_fail++; $display("FAIL %s_idle: got busy=%b want 0", tag, bus0.BUSY); end
  endtask

  task automatic test_round_robin();
    rst_n0 = 1'b0; tick(); rst_n0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus0.ADDR[i*3 +: 3] = 3'(i + 1);
      bus0.DATA[i*8 +: 8] = 8'(8'h10 + i);
    end
    serve_sequence(4'b1111, 0, 1, 2, 3, 4, "rr_all");
    serve_sequence(4'b0010, 1, 0, 0, 0, 1, "rr_setup");
    serve_sequence(4'b1011, 3, 0, 1, 0, 3, "rr_ptr2");
  endtask

  task automatic test_preset_priority();
    logic [7:0] exp_g;
    logic [3:0] exp_gnt;
    bus0.ADDR[0 +: 3] = 3'd1; bus0.DATA[0 +: 8] = 8'h5A;
    bus0.REQ = 4'b0001; bus0.PRE_REQ = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_g   = (c >= 4 && c <= 6) ? 8'h02 : 8'h00;
      exp_gnt = (c == 7) ? 4'b0001 : 4'b0000;
      n_checks++; if (bus0.LAT_PRE !== (c == 1)) begin n_fail++; $display("FAIL pre_lat_pre c%0d: got %b want %b", c, bus0.LAT_PRE, (c == 1)); end
      n_checks++; if (bus0.PRE_ACK !== (c == 2)) begin n_fail++; $display("FAIL pre_ack c%0d: got %b want %b", c, bus0.PRE_ACK, (c == 2)); end
      n_checks++; if (bus0.LAT_GE !== (c == 5)) begin n_fail++; $display("FAIL pre_lat_ge c%0d: got %b want %b", c, bus0.LAT_GE, (c == 5)); end
      n_checks++; if (bus0.LAT_G !== exp_g) begin n_fail++; $display("FAIL pre_lat_g c%0d: got %h want %h", c, bus0.LAT_G, exp_g); end
      n_checks++; if (bus0.GNT !== exp_gnt) begin n_fail++; $display("FAIL pre_gnt c%0d: got %b want %b", c, bus0.GNT, exp_gnt); end
      n_checks++; if (bus0.BUSY !== (c != 3 && c <= 7)) begin n_fail++; $display("FAIL pre_busy c%0d: got %b want %b", c, bus0.BUSY, (c != 3 && c <= 7)); end
      if (c == 2) bus0.PRE_REQ = 1'b0;
      if (c == 7) bus0.REQ = 4'b0000;
    end
  endtask

  task automatic test_stretched();
    logic [7:0] prev_d;
    logic [7:0] prev_g;
    logic       prev_ge;
    logic [7:0] exp_g;
    logic [3:0] exp_gnt;
    prev_d = bus1.LAT_D; prev_g = bus1.LAT_G; prev_ge = bus1.LAT_GE;
    bus1.ADDR[1*3 +: 3] = 3'd3; bus1.DATA[1*8 +: 8] = 8'h3C; bus1.REQ = 4'b0010;
    for (int c = 1; c <= 9; c++) begin
      tick();
      exp_g   = (c <= 6) ? 8'h08 : 8'h00;
      exp_gnt = (c == 7) ? 4'b0010 : 4'b0000;
      n_checks++; if (bus1.LAT_GE !== (c == 4)) begin n_fail++; $display("FAIL str_lat_ge c%0d: got %b want %b", c, bus1.LAT_GE, (c == 4)); end
      n_checks++; if (bus1.GNT !== exp_gnt) begin n_fail++; $display("FAIL str_gnt c%0d: got %b want %b", c, bus1.GNT, exp_gnt); end
      n_checks++; if (bus1.LAT_G !== exp_g) begin n_fail++; $display("FAIL str_lat_g c%0d: got %h want %h", c, bus1.LAT_G, exp_g); end
      n_checks++; if (bus1.LAT_D !== 8'h3C) begin n_fail++; $display("FAIL str_lat_d c%0d: got %h want 3c", c, bus1.LAT_D); end
      n_checks++; if (bus1.BUSY !== (c <= 7)) begin n_fail++; $display("FAIL str_busy c%0d: got %b want %b", c, bus1.BUSY, (c <= 7)); end
      if (bus1.LAT_GE || prev_ge) begin
        n_checks++; if (bus1.LAT_D !== prev_d || bus1.LAT_G !== prev_g) begin n_fail++; $display("FAIL str_stable c%0d: got d=%h g=%h want d=%h g=%h", c, bus1.LAT_D, bus1.LAT_G, prev_d, prev_g); end
      end
      prev_d = bus1.LAT_D; prev_g = bus1.LAT_G; prev_ge = bus1.LAT_GE;
      if (c == 7) bus1.REQ = 4'b0000;
    end
  endtask

  task automatic test_reset_abort();
    logic [3:0] exp_gnt;
    bus0.ADDR[1*3 +: 3] = 3'd6; bus0.DATA[1*8 +: 8] = 8'h55;
    bus0.ADDR[3*3 +: 3] = 3'd4; bus0.DATA[3*8 +: 8] = 8'h99;
    bus0.REQ = 4'b0010;
    tick(); tick();
    n_checks++; if (bus0.LAT_GE !== 1'b1) begin n_fail++; $display("FAIL abort_open: got ge=%b want 1", bus0.LAT_GE); end
    rst_n0 = 1'b0; bus0.REQ = 4'b0000;
    tick();
    n_checks++; if (bus0.LAT_GE !== 1'b0 || bus0.LAT_G !== 8'h00 || bus0.LAT_D !== 8'h00) begin n_fail++; $display("FAIL abort_lat: got ge=%b g=%h d=%h want 0/00/00", bus0.LAT_GE, bus0.LAT_G, bus0.LAT_D); end
    n_checks++; if (bus0.BUSY !== 1'b0 || bus0.GNT !== 4'b0000 || bus0.PRE_ACK !== 1'b0 || bus0.LAT_PRE !== 1'b0) begin n_fail++; $display("FAIL abort_ctl: got busy=%b gnt=%b ack=%b pre=%b want zeros", bus0.BUSY, bus0.GNT, bus0.PRE_ACK, bus0.LAT_PRE); end
    rst_n0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (bus0.GNT !== 4'b0000 || bus0.BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_quiet%0d: got gnt=%b busy=%b want 0000/0", c, bus0.GNT, bus0.BUSY); end
    end
    bus0.REQ = 4'b1010;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp_gnt = (c == 4) ? 4'b0010 : ((c == 9) ? 4'b1000 : 4'b0000);
      n_checks++; if (bus0.GNT !== exp_gnt) begin n_fail++; $display("FAIL abort_after_gnt c%0d: got %b want %b", c, bus0.GNT, exp_gnt); end
      if (c == 1) begin
        n_checks++; if (bus0.LAT_G !== 8'h40) begin n_fail++; $display("FAIL abort_after_g1: got %h want 40", bus0.LAT_G); end
      end
      if (c == 6) begin
        n_checks++; if (bus0.LAT_G !== 8'h10 || bus0.LAT_D !== 8'h99) begin n_fail++; $display("FAIL abort_after_g3: got g=%h d=%h want 10/99", bus0.LAT_G, bus0.LAT_D); end
      end
      bus0.REQ = bus0.REQ & ~bus0.GNT;
    end
  endtask

  task automatic test_input_change();
    logic [7:0] exp_g;
    logic [3:0] exp_gnt;
    bus0.ADDR[3*3 +: 3] = 3'd2; bus0.DATA[3*8 +: 8] = 8'h81; bus0.REQ = 4'b1000;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_g   = (c <= 3) ? 8'h04 : 8'h00;
      exp_gnt = (c == 4) ? 4'b1000 : 4'b0000;
      n_checks++; if (bus0.LAT_D !== 8'h81) begin n_fail++; $display("FAIL chg_lat_d c%0d: got %h want 81", c, bus0.LAT_D); end
      n_checks++; if (bus0.LAT_G !== exp_g) begin n_fail++; $display("FAIL chg_lat_g c%0d: got %h want %h", c, bus0.LAT_G, exp_g); end
      n_checks++; if (bus0.GNT !== exp_gnt) begin n_fail++; $display("FAIL chg_gnt c%0d: got %b want %b", c, bus0.GNT, exp_gnt); end
      if (c == 2) begin
        bus0.ADDR[3*3 +: 3] = 3'd7; bus0.DATA[3*8 +: 8] = 8'hFF;
      end
      if (c == 4) bus0.REQ = 4'b0000;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_preset_priority();
    test_stretched();
    test_reset_abort();
    test_input_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
